// File: rtl/hue_fade_if.sv
// ---------------------------------------------------------------------------
// hue_fade_if
// Bundles the sequencer's control input and its observable outputs so the
// sequencer and whatever drives the LED pins share one typed connection.
//
// Signals
//   enable       : 1 = hue sequence advances, 0 = sequence frozen
//   red_duty     : current red duty, 0..full scale
//   green_duty   : current green duty
//   blue_duty    : current blue duty
//   segment      : current hue segment, 0..5
//   segment_done : one-cycle pulse on the edge the segment advances
//   red_pwm      : registered PWM pin drive
//   green_pwm    : registered PWM pin drive
//   blue_pwm     : registered PWM pin drive
//
// Modports
//   master : the sequencer (consumes enable, drives everything else)
//   slave  : the consumer / pin side
// ---------------------------------------------------------------------------
interface hue_fade_if #(
  parameter int DUTY_W = 12
) ();

  logic              enable;
  logic [DUTY_W-1:0] red_duty;
  logic [DUTY_W-1:0] green_duty;
  logic [DUTY_W-1:0] blue_duty;
  logic [2:0]        segment;
  logic              segment_done;
  logic              red_pwm;
  logic              green_pwm;
  logic              blue_pwm;

  modport master (
    input  enable,
    output red_duty, green_duty, blue_duty,
    output segment, segment_done,
    output red_pwm, green_pwm, blue_pwm
  );

  modport slave (
    output enable,
    input  red_duty, green_duty, blue_duty,
    input  segment, segment_done,
    input  red_pwm, green_pwm, blue_pwm
  );

endinterface

// File: rtl/hue_fade_sequencer.sv
// ---------------------------------------------------------------------------
// hue_fade_sequencer
// Walks three PWM duty channels around a 6-segment hue wheel. Each segment
// ramps one channel linearly (one DUTY_STEP per step tick) while the other
// two hold. A prescaler derives step ticks from clk; a free-running PWM
// counter drives three glitch-free PWM outputs whose duties are shadowed and
// only reloaded at period boundaries.
//
// Ports
//   clk_i   : system clock
//   reset_i : synchronous, active-high reset (dominates everything)
//   hue_if  : hue_fade_if.master -- enable in; duties, segment,
//             segment_done and the three PWM pins out
// ---------------------------------------------------------------------------
module hue_fade_sequencer #(
  parameter int STEP_INTERVAL     = 12000,
  parameter int STEPS_PER_SEGMENT = 200,
  parameter int PWM_INTERVAL      = 1200,
  parameter int DUTY_STEP         = PWM_INTERVAL / STEPS_PER_SEGMENT
) (
  input  logic       clk_i,
  input  logic       reset_i,
  hue_fade_if.master hue_if
);

  // Duty needs one bit more than the counter so it can hold PWM_INTERVAL itself.
  localparam int DUTY_W = $clog2(PWM_INTERVAL) + 1;
  localparam int PRE_W  = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int STEP_W = (STEPS_PER_SEGMENT > 1) ? $clog2(STEPS_PER_SEGMENT) : 1;
  localparam int CNT_W  = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;

  localparam logic [DUTY_W-1:0] FULL_C      = DUTY_W'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] STEP_C      = DUTY_W'(DUTY_STEP);
  localparam logic [DUTY_W-1:0] HEADROOM_C  = DUTY_W'(PWM_INTERVAL - DUTY_STEP);
  localparam logic [PRE_W-1:0]  PRE_LAST_C  = PRE_W'(STEP_INTERVAL - 1);
  localparam logic [STEP_W-1:0] STEP_LAST_C = STEP_W'(STEPS_PER_SEGMENT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST_C  = CNT_W'(PWM_INTERVAL - 1);

  localparam int RED = 0;
  localparam int GRN = 1;
  localparam int BLU = 2;

  // Segment names: which channel ramps and in which direction.
  typedef enum logic [2:0] {
    SEG_G_UP = 3'd0,
    SEG_R_DN = 3'd1,
    SEG_B_UP = 3'd2,
    SEG_G_DN = 3'd3,
    SEG_R_UP = 3'd4,
    SEG_B_DN = 3'd5
  } seg_e;

  // Rising step; the headroom compare happens before the add so it never wraps.
  function automatic logic [DUTY_W-1:0] ramp_up(input logic [DUTY_W-1:0] v,
                                                 input logic snap);
    logic [DUTY_W-1:0] r;
    if (snap) begin
      r = FULL_C;
    end else if (v >= HEADROOM_C) begin
      r = FULL_C;
    end else begin
      r = v + STEP_C;
    end
    return r;
  endfunction

  // Falling step; compared against the step size before subtracting.
  function automatic logic [DUTY_W-1:0] ramp_dn(input logic [DUTY_W-1:0] v,
                                                 input logic snap);
    logic [DUTY_W-1:0] r;
    if (snap) begin
      r = '0;
    end else if (v <= STEP_C) begin
      r = '0;
    end else begin
      r = v - STEP_C;
    end
    return r;
  endfunction

  seg_e              seg_q, seg_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DUTY_W-1:0] duty_q [3];
  logic [DUTY_W-1:0] duty_d [3];
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] shadow_q [3];
  logic [DUTY_W-1:0] shadow_d [3];
  logic [2:0]        pwm_q, pwm_d;
  logic              tick_s;
  logic              last_s;
  logic              wrap_s;

  assign tick_s = hue_if.enable && (pre_q == PRE_LAST_C);
  // The final tick of a segment snaps the ramp to its endpoint and advances.
  assign last_s = tick_s && (step_q == STEP_LAST_C);
  assign wrap_s = (cnt_q == CNT_LAST_C);

  // Segment state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      seg_q <= SEG_G_UP;
    end else begin
      seg_q <= seg_d;
    end
  end

  // Segment next-state: advance around the wheel on the last step of a segment.
  always_comb begin
    seg_d = seg_q;
    if (last_s) begin
      case (seg_q)
        SEG_G_UP: seg_d = SEG_R_DN;
        SEG_R_DN: seg_d = SEG_B_UP;
        SEG_B_UP: seg_d = SEG_G_DN;
        SEG_G_DN: seg_d = SEG_R_UP;
        SEG_R_UP: seg_d = SEG_B_DN;
        SEG_B_DN: seg_d = SEG_G_UP;
        default:  seg_d = SEG_G_UP;
      endcase
    end else begin
      seg_d = seg_q;
    end
  end

  // Prescaler, step counter and duty ramp next-state.
  always_comb begin
    pre_d  = pre_q;
    step_d = step_q;
    duty_d = duty_q;
    done_d = last_s;
    if (tick_s) begin
      pre_d  = '0;
      step_d = last_s ? '0 : (step_q + STEP_W'(1));
      case (seg_q)
        SEG_G_UP: duty_d[GRN] = ramp_up(duty_q[GRN], last_s);
        SEG_R_DN: duty_d[RED] = ramp_dn(duty_q[RED], last_s);
        SEG_B_UP: duty_d[BLU] = ramp_up(duty_q[BLU], last_s);
        SEG_G_DN: duty_d[GRN] = ramp_dn(duty_q[GRN], last_s);
        SEG_R_UP: duty_d[RED] = ramp_up(duty_q[RED], last_s);
        SEG_B_DN: duty_d[BLU] = ramp_dn(duty_q[BLU], last_s);
        default:  duty_d      = duty_q;
      endcase
    end else if (hue_if.enable) begin
      pre_d = pre_q + PRE_W'(1);
    end else begin
      pre_d = pre_q;
    end
  end

  // Sequencer datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pre_q       <= '0;
      step_q      <= '0;
      duty_q[RED] <= FULL_C;
      duty_q[GRN] <= '0;
      duty_q[BLU] <= '0;
      done_q      <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      step_q <= step_d;
      duty_q <= duty_d;
      done_q <= done_d;
    end
  end

  // PWM next-state: shadows reload from the pre-tick duty only at the wrap,
  // and each pin compares the counter with the shadow of the current period.
  always_comb begin
    cnt_d    = wrap_s ? '0 : (cnt_q + CNT_W'(1));
    shadow_d = shadow_q;
    pwm_d    = 3'b000;
    if (wrap_s) begin
      shadow_d = duty_q;
    end else begin
      shadow_d = shadow_q;
    end
    for (int ch = 0; ch < 3; ch++) begin
      pwm_d[ch] = (DUTY_W'(cnt_q) < shadow_q[ch]);
    end
  end

  // PWM counter, shadow duties and registered pin drives.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q         <= '0;
      shadow_q[RED] <= FULL_C;
      shadow_q[GRN] <= '0;
      shadow_q[BLU] <= '0;
      pwm_q         <= 3'b000;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign hue_if.red_duty     = duty_q[RED];
  assign hue_if.green_duty   = duty_q[GRN];
  assign hue_if.blue_duty    = duty_q[BLU];
  assign hue_if.segment      = seg_q;
  assign hue_if.segment_done = done_q;
  assign hue_if.red_pwm      = pwm_q[RED];
  assign hue_if.green_pwm    = pwm_q[GRN];
  assign hue_if.blue_pwm     = pwm_q[BLU];

endmodule

// File: tb/tb_hue_fade_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hue_fade_sequencer
// Two sequencers share clock, reset and enable: dut_a uses the standard
// small configuration (step 4, 5 steps/segment, PWM 10, duty step 2) and
// dut_b the inexact one (3 steps/segment, duty step 3) to exercise the
// endpoint snap. A model derives every expected output from the number of
// enabled cycles and PWM cycles since reset.
// ---------------------------------------------------------------------------
module tb_hue_fade_sequencer;

  localparam int SI = 4;
  localparam int P  = 10;

  logic clk_s = 1'b0;
  logic reset_s;
  logic en_s;

  always #5 clk_s = ~clk_s;

  hue_fade_if #(.DUTY_W(5)) bus_a ();
  hue_fade_if #(.DUTY_W(5)) bus_b ();

  assign bus_a.enable = en_s;
  assign bus_b.enable = en_s;

  hue_fade_sequencer #(
    .STEP_INTERVAL(4), .STEPS_PER_SEGMENT(5), .PWM_INTERVAL(10), .DUTY_STEP(2)
  ) dut_a (
    .clk_i(clk_s), .reset_i(reset_s), .hue_if(bus_a)
  );

  hue_fade_sequencer #(
    .STEP_INTERVAL(4), .STEPS_PER_SEGMENT(3), .PWM_INTERVAL(10), .DUTY_STEP(3)
  ) dut_b (
    .clk_i(clk_s), .reset_i(reset_s), .hue_if(bus_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  int e_cnt  = 0;        // enabled cycles since reset
  int pc_cnt = 0;        // cycles since reset (PWM time base)
  int sh      [2][3];    // latched duty per DUT/channel
  int exp_pwm [2][3];
  int exp_done[2];
  bit model_valid = 1'b0;

  function automatic int steps_of(input int d);
    return (d == 0) ? 5 : 3;
  endfunction

  function automatic int dstep_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  // Duty of channel ch after n step ticks, from the hue-wheel table.
  function automatic int exp_duty(input int d, input int ch, input int n);
    int s, k, up, dn;
    int v[3];
    s  = (n / steps_of(d)) % 6;
    k  = n % steps_of(d);
    up = (k * dstep_of(d) > P) ? P : k * dstep_of(d);
    dn = P - up;
    case (s)
      0:       v = '{P, up, 0};
      1:       v = '{dn, P, 0};
      2:       v = '{0, P, up};
      3:       v = '{0, dn, P};
      4:       v = '{up, 0, P};
      default: v = '{P, 0, dn};
    endcase
    return v[ch];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    int c, nb;
    if (reset_s) begin
      e_cnt  = 0;
      pc_cnt = 0;
      for (int d = 0; d < 2; d++) begin
        sh[d]       = '{P, 0, 0};
        exp_pwm[d]  = '{0, 0, 0};
        exp_done[d] = 0;
      end
      model_valid = 1'b1;
    end else begin
      c  = pc_cnt % P;
      nb = e_cnt / SI;
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < 3; ch++) begin
          exp_pwm[d][ch] = (c < sh[d][ch]) ? 1 : 0;
          if (c == P - 1) sh[d][ch] = exp_duty(d, ch, nb);
        end
      end
      pc_cnt++;
      if (en_s) e_cnt++;
      for (int d = 0; d < 2; d++) begin
        exp_done[d] = (en_s && (e_cnt % SI == 0) &&
                       ((e_cnt / SI) % steps_of(d) == 0)) ? 1 : 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] act[2][8];
    string nm[8];
    int n;
    nm = '{"red_duty", "green_duty", "blue_duty", "segment",
           "segment_done", "red_pwm", "green_pwm", "blue_pwm"};
    act[0] = '{bus_a.red_duty, bus_a.green_duty, bus_a.blue_duty, bus_a.segment,
               bus_a.segment_done, bus_a.red_pwm, bus_a.green_pwm, bus_a.blue_pwm};
    act[1] = '{bus_b.red_duty, bus_b.green_duty, bus_b.blue_duty, bus_b.segment,
               bus_b.segment_done, bus_b.red_pwm, bus_b.green_pwm, bus_b.blue_pwm};
    n = e_cnt / SI;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 3; ch++) begin
        chk($sformatf("dut%0d %s", d, nm[ch]), act[d][ch], exp_duty(d, ch, n));
        chk($sformatf("dut%0d %s", d, nm[ch + 5]), act[d][ch + 5], exp_pwm[d][ch]);
      end
      chk($sformatf("dut%0d %s", d, nm[3]), act[d][3], (n / steps_of(d)) % 6);
      chk($sformatf("dut%0d %s", d, nm[4]), act[d][4], exp_done[d]);
    end
  endtask

  // Model advances on each rising edge using the inputs held across it.
  initial begin
    forever begin
      @(posedge clk_s);
      model_step();
    end
  end

  // Single compare process, sampling away from the active edge.
  initial begin
    forever begin
      @(negedge clk_s);
      if (model_valid) compare_all();
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk_s);
  endtask

  int  pulses;
  int  hi_r, hi_g, hi_b;
  bit  found;

  initial begin
    reset_s = 1'b1;
    en_s    = 1'b1;
    run(2);
    reset_s = 1'b0;

    // First ramp of segment 0 and the inexact snap in dut_b
    run(4);
    chk("a green after 4", bus_a.green_duty, 2);
    chk("b green after 4", bus_b.green_duty, 3);
    run(4);
    chk("a green after 8", bus_a.green_duty, 4);
    chk("b green after 8", bus_b.green_duty, 6);
    run(4);
    chk("b green snap", bus_b.green_duty, 10);
    chk("b segment after 12", bus_b.segment, 1);
    run(4);
    chk("b red after 16", bus_b.red_duty, 7);
    run(4);
    chk("a green after 20", bus_a.green_duty, 10);
    chk("a segment after 20", bus_a.segment, 1);
    chk("a done after 20", bus_a.segment_done, 1);
    chk("b red after 20", bus_b.red_duty, 4);
    run(1);
    chk("a done one cycle", bus_a.segment_done, 0);

    // Remainder of the full wheel (120 enabled cycles total)
    pulses = 1;
    repeat (99) begin
      @(negedge clk_s);
      if (bus_a.segment_done === 1'b1) begin
        pulses++;
        chk("a segment order", bus_a.segment, pulses % 6);
      end
    end
    chk("a done pulses", pulses, 6);
    chk("a wheel segment", bus_a.segment, 0);
    chk("a wheel red", bus_a.red_duty, 10);
    chk("a wheel green", bus_a.green_duty, 0);
    chk("a wheel blue", bus_a.blue_duty, 0);

    // Freeze with prescaler at 2, then resume
    run(2);
    en_s = 1'b0;
    run(50);
    chk("a green frozen", bus_a.green_duty, 0);
    en_s = 1'b1;
    run(1);
    chk("a green resume+1", bus_a.green_duty, 0);
    run(1);
    chk("a green resume+2", bus_a.green_duty, 2);

    // PWM shape with green held at 4
    run(4);
    chk("a green held", bus_a.green_duty, 4);
    en_s = 1'b0;
    run(12);
    hi_r = 0;
    hi_g = 0;
    hi_b = 0;
    repeat (20) begin
      @(negedge clk_s);
      hi_r += int'(bus_a.red_pwm);
      hi_g += int'(bus_a.green_pwm);
      hi_b += int'(bus_a.blue_pwm);
    end
    chk("a red pwm highs", hi_r, 20);
    chk("a green pwm highs", hi_g, 8);
    chk("a blue pwm highs", hi_b, 0);

    // Reset mid-segment 3
    en_s  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_s);
      if (bus_a.segment === 3'd3) found = 1'b1;
    end
    chk("a reach segment 3", found, 1);
    run(5);
    reset_s = 1'b1;
    run(1);
    reset_s = 1'b0;
    chk("a reset red", bus_a.red_duty, 10);
    chk("a reset green", bus_a.green_duty, 0);
    chk("a reset blue", bus_a.blue_duty, 0);
    chk("a reset segment", bus_a.segment, 0);
    chk("a reset pwm", {bus_a.red_pwm, bus_a.green_pwm, bus_a.blue_pwm}, 0);
    chk("b reset pwm", {bus_b.red_pwm, bus_b.green_pwm, bus_b.blue_pwm}, 0);
    run(4);
    chk("a green restart", bus_a.green_duty, 2);
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hue_fade_sequencer.md
Name: hue_fade_sequencer

Overview:
- Controller that sequences three PWM duty channels (red, green, blue) through a continuous 6-segment hue wheel.
- Each segment ramps one channel linearly while the other two hold.
- Contains its own step prescaler, segment FSM, and three glitch-free PWM generators with shadowed duty registers.
- Sits between the top-level clock and the RGB LED pins. It is the sequencer for the fade/PWM datapath.

Parameters:
- STEP_INTERVAL, 12000, clk cycles per duty step (1 ms at 12 MHz).
- STEPS_PER_SEGMENT, 200, duty steps per hue segment.
- PWM_INTERVAL, 1200, PWM period in clk cycles; also full-scale duty.
- DUTY_STEP, PWM_INTERVAL/STEPS_PER_SEGMENT, duty increment or decrement per step.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = sequence advances; 0 = sequence frozen, PWM keeps running
- red_duty  output  $clog2(PWM_INTERVAL)+1  current red duty, range 0..PWM_INTERVAL
- green_duty  output  $clog2(PWM_INTERVAL)+1  current green duty
- blue_duty  output  $clog2(PWM_INTERVAL)+1  current blue duty
- segment  output  3  current hue segment, 0..5
- segment_done  output  1  one-cycle pulse on segment advance
- red_pwm  output  1  registered PWM output
- green_pwm  output  1  registered PWM output
- blue_pwm  output  1  registered PWM output

Behaviour:
- Reset is synchronous and active-high and dominates all other inputs. On the edge where reset=1, every register takes its reset value:
  - red_duty=PWM_INTERVAL, green_duty=0, blue_duty=0
  - segment=0, segment_done=0
  - prescaler=0, step count=0, PWM counter=0
  - shadow duties = R:PWM_INTERVAL, G:0, B:0
  - all *_pwm outputs = 0
- Reset mid-segment or mid-PWM-period abandons all progress.
- Prescaler: counts 0..STEP_INTERVAL-1 only while enable=1, and holds while enable=0.
  - A step tick is the edge where the prescaler=STEP_INTERVAL-1 and enable=1. On that edge the prescaler wraps to 0.
  - Duty updates take effect on that same edge, so the first update comes STEP_INTERVAL enabled cycles after reset.
- Segment FSM (rising channel, falling channel, channel held at full):
  - 0: G rises, R held full
  - 1: R falls, G held full
  - 2: B rises, G held full
  - 3: G falls, B held full
  - 4: R rises, B held full
  - 5: B falls, R held full
  - 5 wraps to 0. Channels not named stay constant.
- On each step tick:
  - The rising channel gets += DUTY_STEP, saturating at PWM_INTERVAL.
  - The falling channel gets -= DUTY_STEP, saturating at 0.
  - The step count increments.
- Last tick of a segment (step count = STEPS_PER_SEGMENT-1):
  - The ramping channel snaps to its exact endpoint: PWM_INTERVAL if rising, 0 if falling. This removes the residual when the division is inexact.
  - Step count returns to 0 and segment advances.
  - segment_done=1 for exactly that one cycle, registered on the same edge as the segment change.
- enable=0 freezes the prescaler, step count, segment, and duties. Re-asserting enable resumes from the frozen prescaler value; no tick is lost or duplicated.
- PWM counter: free-running 0..PWM_INTERVAL-1, independent of enable.
  - At the edge where the counter=PWM_INTERVAL-1, each shadow duty loads the current *_duty value. Duty changes therefore apply only at period boundaries, so no glitches occur.
  - *_pwm is registered as (counter < shadow). It lags the counter by one cycle.
  - Duty 0 gives constant 0; duty PWM_INTERVAL gives constant 1.
- Simultaneous step tick and PWM wrap: the shadow captures the pre-tick duty; the new duty applies from the next period.
- Width: duty registers are $clog2(PWM_INTERVAL)+1 bits so they hold PWM_INTERVAL exactly. Saturation compares are done before the add/subtract, so no wrap-around occurs.

Test Plan:
Benches use STEP_INTERVAL=4, STEPS_PER_SEGMENT=5, PWM_INTERVAL=10, DUTY_STEP=2 unless stated otherwise.
- Reset then hold enable=1: after 4 edges, green_duty=2; after 8 edges, 4; after 20 edges, green_duty=10, segment=1, and segment_done high for exactly 1 cycle. R stays 10, B stays 0 throughout.
- Full wheel: after 120 enabled cycles, segment=0, R=10, G=0, B=0. There are exactly 6 segment_done pulses, and segment order is 0,1,2,3,4,5,0.
- Snap with STEPS_PER_SEGMENT=3, DUTY_STEP=3: green_duty sequence is 3, 6, 10 (not 9). In segment 1, red_duty sequence is 7, 4, 0.
- enable dropped for 50 cycles at prescaler=2 during segment 0: duties, segment, and segment_done stay frozen while *_pwm keep toggling. The next tick comes 2 enabled cycles after re-enable.
- PWM shape: red constant 1 at duty 10, blue constant 0. With green_duty=4 latched, green_pwm is high 4 of every 10 cycles. A duty change mid-period does not alter the current period.
- Assert reset for 1 cycle mid-segment 3: the next cycle shows R=10, G=0, B=0, segment=0, all pwm=0. The sequence restarts with G=2 four cycles later.
